nbit_counter_updown_mod: RTL and testbench

//  Generalised up/down counter: runtime step, runtime modulus (max_val), wrap or saturate mode,

---
 rtl/nbit_counter_updown_mod_pkg.sv | 15 +
 rtl/nbit_counter_updown_mod_if.sv | 38 +++
 rtl/nbit_counter_updown_mod_next_calc.sv | 73 +++++++
 rtl/nbit_counter_updown_mod.sv | 86 ++++++++
 tb/tb_nbit_counter_updown_mod.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/nbit_counter_updown_mod_pkg.sv
//------------------------------------------------------------------------------
// Module : counter_pkg
// Brief  : Shared encodings for the up/down counter slice.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package counter_pkg;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
endpackage

`default_nettype wire

// File: rtl/nbit_counter_updown_mod_if.sv
//------------------------------------------------------------------------------
// Module : nbit_counter_updown_mod_if
// Brief  : Control/status bundle of the up/down counter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface nbit_counter_updown_mod_if #(
  parameter int CNT_WIDTH  = 8,
  parameter int STEP_WIDTH = 4
);
  logic                  en;
  logic                  count_up_down;
  logic [STEP_WIDTH-1:0] step;
  logic [CNT_WIDTH-1:0]  max_val;
  logic                  sat_mode;
  logic                  load;
  logic [CNT_WIDTH-1:0]  load_val;
  logic                  clr_err;
  logic [CNT_WIDTH-1:0]  counter;
  logic                  tc_up;
  logic                  tc_down;
  logic                  at_max;
  logic                  at_min;
  logic                  err_sticky;

  modport master (
    output en, count_up_down, step, max_val, sat_mode, load, load_val, clr_err,
    input  counter, tc_up, tc_down, at_max, at_min, err_sticky
  );

  modport slave (
    input  en, count_up_down, step, max_val, sat_mode, load, load_val, clr_err,
    output counter, tc_up, tc_down, at_max, at_min, err_sticky
  );
endinterface

`default_nettype wire

// File: rtl/nbit_counter_updown_mod_next_calc.sv
//------------------------------------------------------------------------------
// Module : counter_next_calc
// Brief  : Combinational next-count, wrap/saturation events and illegal-step flag.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module counter_next_calc
  import counter_pkg::*;
#(
  parameter int CNT_WIDTH  = 8,
  parameter int STEP_WIDTH = 4
) (
  input  wire logic [CNT_WIDTH-1:0]  counter,
  input  wire logic [STEP_WIDTH-1:0] step,
  input  wire logic [CNT_WIDTH-1:0]  max_val,
  input  wire logic                  dir,
  input  wire logic                  mode,
  output logic      [CNT_WIDTH-1:0]  nxt,
  output logic                       wrap_up,
  output logic                       wrap_dn,
  output logic                       illegal
);
  // One guard bit above the wider operand keeps every sum/difference exact.
  localparam int EXT_W = ((CNT_WIDTH > STEP_WIDTH) ? CNT_WIDTH : STEP_WIDTH) + 1;

  logic [EXT_W-1:0] w_cnt;
  logic [EXT_W-1:0] w_step;
  logic [EXT_W-1:0] w_max;
  logic [EXT_W-1:0] w_max_p1;
  logic [EXT_W-1:0] w_sum;
  logic [EXT_W-1:0] w_res;
  logic             w_unused_hi;

  assign w_cnt    = EXT_W'(counter);
  assign w_step   = EXT_W'(step);
  assign w_max    = EXT_W'(max_val);
  assign w_max_p1 = w_max + EXT_W'(1);
  assign w_sum    = w_cnt + w_step;

  always_comb begin
    w_res   = w_cnt;
    wrap_up = 1'b0;
    wrap_dn = 1'b0;
    illegal = (mode == MODE_WRAP) && (w_step > w_max);
    if (dir == DIR_UP) begin
      if (w_sum <= w_max) begin
        w_res = w_sum;
      end else if (mode == MODE_WRAP) begin
        w_res   = w_sum - w_max_p1;
        wrap_up = 1'b1;
      end else begin
        w_res   = w_max;
        wrap_up = (w_cnt != w_max);
      end
    end else begin
      if (w_cnt >= w_step) begin
        w_res = w_cnt - w_step;
      end else if (mode == MODE_WRAP) begin
        w_res   = w_cnt + w_max_p1 - w_step;
        wrap_dn = 1'b1;
      end else begin
        w_res   = '0;
        wrap_dn = (w_cnt != '0);
      end
    end
  end

  assign nxt         = w_res[CNT_WIDTH-1:0];
  assign w_unused_hi = ^w_res[EXT_W-1:CNT_WIDTH];
endmodule

`default_nettype wire

// File: rtl/nbit_counter_updown_mod.sv
//------------------------------------------------------------------------------
// Module : nbit_counter_updown_mod
// Brief  : Up/down counter with runtime step/modulus, wrap or saturate, load and sticky error.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module nbit_counter_updown_mod
  import counter_pkg::*;
#(
  parameter int CNT_WIDTH  = 8,
  parameter int STEP_WIDTH = 4,
  parameter int RESET_VAL  = 0
) (
  input wire logic                clk,
  input wire logic                reset,
  nbit_counter_updown_mod_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] C_RESET_VAL = CNT_WIDTH'(RESET_VAL);

  logic [CNT_WIDTH-1:0] r_counter;
  logic                 r_tc_up;
  logic                 r_tc_dn;
  logic                 r_err;

  logic [CNT_WIDTH-1:0] w_nxt;
  logic                 w_wrap_up;
  logic                 w_wrap_dn;
  logic                 w_illegal;
  logic                 w_load_over;
  logic                 w_step_act;
  logic                 w_err_set;

  counter_next_calc #(
    .CNT_WIDTH  (CNT_WIDTH),
    .STEP_WIDTH (STEP_WIDTH)
  ) u_next_calc (
    .counter (r_counter),
    .step    (bus.step),
    .max_val (bus.max_val),
    .dir     (bus.count_up_down),
    .mode    (bus.sat_mode),
    .nxt     (w_nxt),
    .wrap_up (w_wrap_up),
    .wrap_dn (w_wrap_dn),
    .illegal (w_illegal)
  );

  assign w_load_over = (bus.load_val > bus.max_val);
  assign w_step_act  = bus.en && (bus.step != '0);
  // Load has priority, so an illegal step is only flagged when no load is present.
  assign w_err_set   = bus.load ? w_load_over : (w_step_act && w_illegal);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_counter <= C_RESET_VAL;
      r_tc_up   <= 1'b0;
      r_tc_dn   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_tc_up <= 1'b0;
      r_tc_dn <= 1'b0;
      if (bus.load) begin
        r_counter <= w_load_over ? bus.max_val : bus.load_val;
      end else if (w_step_act && !w_illegal) begin
        r_counter <= w_nxt;
        r_tc_up   <= w_wrap_up;
        r_tc_dn   <= w_wrap_dn;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (bus.clr_err) begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.counter    = r_counter;
  assign bus.tc_up      = r_tc_up;
  assign bus.tc_down    = r_tc_dn;
  assign bus.at_max     = (r_counter == bus.max_val);
  assign bus.at_min     = (r_counter == '0);
  assign bus.err_sticky = r_err;
endmodule

`default_nettype wire

// File: tb/tb_nbit_counter_updown_mod.sv
//------------------------------------------------------------------------------
// Module : tb_nbit_counter_updown_mod
// Brief  : Directed self-checking bench for nbit_counter_updown_mod.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_nbit_counter_updown_mod;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  nbit_counter_updown_mod_if #(.CNT_WIDTH(8), .STEP_WIDTH(4)) bus ();

  nbit_counter_updown_mod #(
    .CNT_WIDTH  (8),
    .STEP_WIDTH (4),
    .RESET_VAL  (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] cnt, input logic tcu,
                             input logic tcd, input logic err);
    check({tag, "_cnt"}, 32'(bus.counter), 32'(cnt));
    check({tag, "_tcu"}, 32'(bus.tc_up), 32'(tcu));
    check({tag, "_tcd"}, 32'(bus.tc_down), 32'(tcd));
    check({tag, "_err"}, 32'(bus.err_sticky), 32'(err));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.en = 1'b0;
    bus.count_up_down = 1'b1;
    bus.step     = 4'd1;
    bus.max_val  = 8'd9;
    bus.sat_mode = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 8'd0;
    bus.clr_err  = 1'b0;
    tick();
    tick();
    check_state("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    check("reset_at_min", 32'(bus.at_min), 32'd1);
    check("reset_at_max", 32'(bus.at_max), 32'd0);

    // 1: wrap count 0..9 with max_val=9
    reset  = 1'b0;
    bus.en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_state($sformatf("up_wrap%0d", i), 8'(i % 10), (i == 10), 1'b0, 1'b0);
      if (i == 9) check("up_at_max", 32'(bus.at_max), 32'd1);
    end

    // 2: load 3 then down by 5 wraps to 8
    bus.en = 1'b0;
    bus.load = 1'b1;
    bus.load_val = 8'd3;
    tick();
    check_state("load3", 8'd3, 1'b0, 1'b0, 1'b0);
    bus.load = 1'b0;
    bus.en = 1'b1;
    bus.count_up_down = 1'b0;
    bus.step = 4'd5;
    tick();
    check_state("dn_wrap", 8'd8, 1'b0, 1'b1, 1'b0);
    bus.en = 1'b0;
    tick();
    check_state("dn_hold", 8'd8, 1'b0, 1'b0, 1'b0);

    // 3: saturate mode
    bus.sat_mode = 1'b1;
    bus.max_val = 8'd10;
    bus.load = 1'b1;
    bus.load_val = 8'd8;
    tick();
    check_state("sat_load8", 8'd8, 1'b0, 1'b0, 1'b0);
    bus.load = 1'b0;
    bus.en = 1'b1;
    bus.count_up_down = 1'b1;
    bus.step = 4'd4;
    tick();
    check_state("sat_up_hit", 8'd10, 1'b1, 1'b0, 1'b0);
    tick();
    check_state("sat_up_stay", 8'd10, 1'b0, 1'b0, 1'b0);
    bus.load = 1'b1;
    bus.load_val = 8'd2;
    tick();
    check_state("sat_load2", 8'd2, 1'b0, 1'b0, 1'b0);
    bus.load = 1'b0;
    bus.count_up_down = 1'b0;
    tick();
    check_state("sat_dn_hit", 8'd0, 1'b0, 1'b1, 1'b0);
    tick();
    check_state("sat_dn_stay", 8'd0, 1'b0, 1'b0, 1'b0);
    check("sat_at_min", 32'(bus.at_min), 32'd1);

    // 4: illegal step, clear, oversize load, set-wins-over-clear
    bus.sat_mode = 1'b0;
    bus.max_val = 8'd5;
    bus.step = 4'd7;
    bus.count_up_down = 1'b1;
    tick();
    check_state("illegal", 8'd0, 1'b0, 1'b0, 1'b1);
    bus.en = 1'b0;
    bus.clr_err = 1'b1;
    tick();
    check_state("clr_err", 8'd0, 1'b0, 1'b0, 1'b0);
    bus.clr_err = 1'b0;
    bus.load = 1'b1;
    bus.load_val = 8'd20;
    tick();
    check_state("load_over", 8'd5, 1'b0, 1'b0, 1'b1);
    bus.clr_err = 1'b1;
    tick();
    check_state("set_wins", 8'd5, 1'b0, 1'b0, 1'b1);
    bus.load = 1'b0;
    tick();
    check_state("clr_again", 8'd5, 1'b0, 1'b0, 1'b0);
    bus.clr_err = 1'b0;

    // 5: load beats enable; step 0 holds
    bus.max_val = 8'd9;
    bus.load = 1'b1;
    bus.en = 1'b1;
    bus.step = 4'd1;
    bus.load_val = 8'd2;
    tick();
    check_state("load_prio", 8'd2, 1'b0, 1'b0, 1'b0);
    bus.load = 1'b0;
    bus.step = 4'd0;
    tick();
    check_state("step0", 8'd2, 1'b0, 1'b0, 1'b0);

    // max_val lowered below counter while idle, then up-count overflows
    bus.en = 1'b0;
    bus.load = 1'b1;
    bus.load_val = 8'd7;
    tick();
    bus.load = 1'b0;
    bus.max_val = 8'd5;
    tick();
    check_state("lowered_idle", 8'd7, 1'b0, 1'b0, 1'b0);
    bus.en = 1'b1;
    bus.step = 4'd1;
    tick();
    check_state("lowered_up", 8'd2, 1'b1, 1'b0, 1'b0);

    // 6: asynchronous reset mid-count at 7 with err set
    bus.max_val = 8'd9;
    bus.en = 1'b0;
    bus.load = 1'b1;
    bus.load_val = 8'd12;
    tick();
    bus.load_val = 8'd5;
    tick();
    bus.load = 1'b0;
    bus.en = 1'b1;
    tick();
    tick();
    check_state("pre_reset", 8'd7, 1'b0, 1'b0, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check_state("async_reset", 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check_state("resume", 8'd1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
